mux_nway_scan: RTL and testbench
================================

Name: mux_nway_scan

Overview:
- Registered, parametrised generalisation of the 8-way 16-bit multiplexer.
- Selects one of WAYS input words of WIDTH bits and registers it.
- Two modes:
  - Direct: explicit select, like the combinational mux with a 1-cycle register stage.
  - Scan: an internal round-robin pointer walks the channels and skips masked-off ones.
- Feeds sampled channel data to downstream registers, RAM write ports or a display/debug path.

Parameters:
- WIDTH, 16, bits per channel word.
- WAYS, 8, number of input channels (2..16; need not be a power of two).
- SEL_W, 3, select/pointer width; must satisfy 2**SEL_W >= WAYS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WAYS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel select, used in direct mode only.
- mode  input  1  0 = direct, 1 = scan.
- en  input  1  update enable.
- mask  input  WAYS  per-channel enable for scan mode; bit k = 1 means channel k is eligible.
- out  output  WIDTH  registered selected word.
- out_sel  output  SEL_W  index of the channel currently held in out.
- out_valid  output  1  out/out_sel were loaded on the last edge.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset (has priority over everything, including mid-scan):
  - out = 0, out_sel = 0, out_valid = 0.
  - Internal pointer ptr = WAYS-1, so the first scan pick is channel 0 if enabled.
- en = 0:
  - out, out_sel and ptr hold.
  - out_valid = 0 on the next edge.
- Direct mode (mode = 0, en = 1):
  - sel < WAYS:
    - Next edge: out = in[sel], out_sel = sel, out_valid = 1, ptr = sel.
    - mask is ignored.
  - sel >= WAYS (only possible when WAYS is not a power of 2):
    - out and out_sel hold, out_valid = 0, ptr holds.
- Scan mode (mode = 1, en = 1):
  - Candidate order: ptr+1, ptr+2, …, wrapping modulo WAYS, with ptr itself checked last.
  - The first candidate with mask[k] = 1 is chosen.
  - Next edge: out = in[k], out_sel = k, out_valid = 1, ptr = k.
  - Only ptr's own channel enabled: it is re-selected every cycle.
  - mask all zero: out, out_sel and ptr hold, out_valid = 0.
  - Wrap-around: after channel WAYS-1, the search continues from channel 0.
- Latency: exactly 1 cycle. out reflects the in/sel/mask values sampled at the loading edge; later changes to in do not affect a held out.
- Mode switching takes effect on the same edge it is sampled:
  - Direct→scan: the scan resumes after the last directly selected channel, because ptr tracks it.
  - Scan→direct: sel applies immediately.
- mask changes mid-scan apply on the next edge; no stale selection is made.
- No X propagation: sel and mask are assumed known whenever en = 1; out never depends on an out-of-range slice.
- Implementation: priority search as combinational logic over a rotated mask (a for-loop is acceptable); no multicycle paths.

Test Plan:
Common setup: WIDTH = 16, WAYS = 8, channel data 0..7 = AAAA, 0000, 1111, 4444, CCCC, FFFF, DDDD, EEEE.

- Reset: assert reset 2 cycles with en = 1 → out = 0000, out_sel = 0, out_valid = 0; ptr = 7 (checked via the first scan pick).
- Direct sweep: mode = 0, en = 1, sel 0..7 on consecutive cycles → one cycle later each: out = AAAA, 0000, 1111, 4444, CCCC, FFFF, DDDD, EEEE; out_sel = sel; out_valid = 1. Change in after the load → out unchanged.
- Scan with mask: reset, mode = 1, en = 1, mask = 8'b1010_0101 → out_sel sequence 0, 2, 5, 7, 0, 2…; out sequence AAAA, 1111, FFFF, EEEE, AAAA…; out_valid = 1 throughout.
- Scan edge cases:
  - mask = 8'b0000_1000 → out_sel = 3 every cycle, out = 4444.
  - mask = 0 → out_valid = 0, out/out_sel hold their last values.
  - mask restored → scanning resumes from the held ptr.
- Enable and mode switch:
  - Direct sel = 4, then en = 0 for 3 cycles → out = CCCC held, out_valid = 0.
  - Then en = 1, mode = 1, mask = FF → out_sel = 5 (FFFF), then 6, 7, 0.
- Reset mid-scan and non-power-of-two config: assert reset during a scan at out_sel = 5 → next edge out = 0, out_valid = 0; the first pick after release is channel 0. With WAYS = 5, SEL_W = 3, direct sel = 6 → out_valid = 0 and out held.

Source files
------------

// File: rtl/mux_nway_scan_if.sv
// Channel-bus bundle for mux_nway_scan: packed channel inputs, select/scan
// controls and the registered selection result.
interface mux_nway_scan_if #(
    parameter int WIDTH = 16,
    parameter int WAYS  = 8,
    parameter int SEL_W = 3
);
    logic [WAYS*WIDTH-1:0] in;
    logic [SEL_W-1:0]      sel;
    logic                  mode;
    logic                  en;
    logic [WAYS-1:0]       mask;
    logic [WIDTH-1:0]      out;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_valid;

    // Source of channel data and controls; consumer of the registered pick
    modport master (
        output in, sel, mode, en, mask,
        input  out, out_sel, out_valid
    );

    // The multiplexer itself
    modport slave (
        input  in, sel, mode, en, mask,
        output out, out_sel, out_valid
    );
endinterface

// File: rtl/mux_nway_scan.sv
// Registered N-way word multiplexer with a direct-select mode and a
// round-robin scan mode that skips masked-off channels.
module mux_nway_scan #(
    parameter int WIDTH = 16,
    parameter int WAYS  = 8,
    parameter int SEL_W = 3
) (
    input logic          clk,
    input logic          reset,
    mux_nway_scan_if.slave bus
);
    // Channels padded to the full select range so any select value indexes
    // a defined (zero) word and never an out-of-range slice.
    localparam int NCH = 2 ** SEL_W;
    localparam logic [SEL_W:0]   WAYS_X  = (SEL_W + 1)'(WAYS);
    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(WAYS - 1);

    logic [WIDTH-1:0] chan [NCH];
    logic [NCH-1:0]   mask_pad;

    logic [SEL_W-1:0] ptr_p1;
    logic [WIDTH-1:0] out_p1;
    logic [SEL_W-1:0] out_sel_p1;
    logic             vld_p1;

    logic             scan_hit;
    logic [SEL_W-1:0] scan_pick;
    logic             sel_ok;
    logic             load;
    logic [SEL_W-1:0] nxt_sel;
    logic [WIDTH-1:0] nxt_word;

    // Index base+step modulo WAYS; base < WAYS and step <= WAYS keep the
    // sum below 2*WAYS, so one conditional subtraction suffices.
    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base,
                                                  input int unsigned      step);
        logic [SEL_W:0] s;
        s = {1'b0, base} + (SEL_W + 1)'(step);
        if (s >= WAYS_X) s = s - WAYS_X;
        return s[SEL_W-1:0];
    endfunction

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        if (k < WAYS) begin : g_used
            assign chan[k] = bus.in[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[k] = '0;
        end
    end

    assign mask_pad = NCH'(bus.mask);
    assign sel_ok   = ({1'b0, bus.sel} < WAYS_X);

    // Round-robin priority search: ptr+1 first, ptr itself last
    always_comb begin
        scan_hit  = 1'b0;
        scan_pick = ptr_p1;
        for (int i = 1; i <= WAYS; i++) begin
            if (!scan_hit && mask_pad[wrap_idx(ptr_p1, i)]) begin
                scan_hit  = 1'b1;
                scan_pick = wrap_idx(ptr_p1, i);
            end
        end
    end

    // Decide whether this edge loads a word and which channel it is
    always_comb begin
        load    = 1'b0;
        nxt_sel = ptr_p1;
        if (bus.en) begin
            if (bus.mode) begin
                load    = scan_hit;
                nxt_sel = scan_pick;
            end else begin
                load    = sel_ok;
                nxt_sel = bus.sel;
            end
        end
    end

    assign nxt_word = chan[nxt_sel];

    // Stage p1: output register and scan pointer; ptr follows every load
    always_ff @(posedge clk) begin
        if (reset) begin
            out_p1     <= '0;
            out_sel_p1 <= '0;
            vld_p1     <= 1'b0;
            ptr_p1     <= PTR_RST;
        end else begin
            vld_p1 <= load;
            if (load) begin
                out_p1     <= nxt_word;
                out_sel_p1 <= nxt_sel;
                ptr_p1     <= nxt_sel;
            end
        end
    end

    assign bus.out       = out_p1;
    assign bus.out_sel   = out_sel_p1;
    assign bus.out_valid = vld_p1;
endmodule

// File: tb/tb_mux_nway_scan.sv
// Directed bench for mux_nway_scan: an 8-way instance for the main sequence
// and a 5-way instance for the non-power-of-two select range.
module tb_mux_nway_scan;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    mux_nway_scan_if #(.WIDTH(16), .WAYS(8), .SEL_W(3)) b8 ();
    mux_nway_scan_if #(.WIDTH(16), .WAYS(5), .SEL_W(3)) b5 ();

    mux_nway_scan #(.WIDTH(16), .WAYS(8), .SEL_W(3)) dut8 (
        .clk(clk), .reset(reset), .bus(b8)
    );
    mux_nway_scan #(.WIDTH(16), .WAYS(5), .SEL_W(3)) dut5 (
        .clk(clk), .reset(reset), .bus(b5)
    );

    always #5 clk = ~clk;

    logic [15:0]  word [8];
    logic [127:0] data8;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [15:0] o, input logic [2:0] s,
                          input logic v);
        check({tag, ".out"}, 32'(b8.out), 32'(o));
        check({tag, ".sel"}, 32'(b8.out_sel), 32'(s));
        check({tag, ".vld"}, 32'(b8.out_valid), 32'(v));
    endtask

    task automatic check5(input string tag, input logic [15:0] o, input logic [2:0] s,
                          input logic v);
        check({tag, ".out"}, 32'(b5.out), 32'(o));
        check({tag, ".sel"}, 32'(b5.out_sel), 32'(s));
        check({tag, ".vld"}, 32'(b5.out_valid), 32'(v));
    endtask

    initial begin
        logic [2:0] seq [6];
        word[0] = 16'hAAAA; word[1] = 16'h0000; word[2] = 16'h1111; word[3] = 16'h4444;
        word[4] = 16'hCCCC; word[5] = 16'hFFFF; word[6] = 16'hDDDD; word[7] = 16'hEEEE;
        for (int k = 0; k < 8; k++) data8[k*16 +: 16] = word[k];

        b8.in = data8; b8.sel = 3'd3; b8.mode = 1'b0; b8.en = 1'b1; b8.mask = 8'hFF;
        b5.in = data8[79:0]; b5.sel = 3'd0; b5.mode = 1'b0; b5.en = 1'b0; b5.mask = 5'h1F;

        // Reset held two cycles with en high
        reset = 1'b1;
        tick(); tick();
        check8("reset", 16'h0000, 3'd0, 1'b0);

        // Direct sweep of every channel
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b8.sel = 3'(i);
            tick();
            check8($sformatf("direct%0d", i), word[i], 3'(i), 1'b1);
        end

        // Held output ignores later input changes
        b8.en = 1'b0;
        b8.in = {8{16'h1234}};
        tick();
        check8("hold_in_change", 16'hEEEE, 3'd7, 1'b0);
        b8.in = data8;

        // Scan from reset with mask 1010_0101
        reset = 1'b1;
        tick();
        reset = 1'b0;
        b8.en = 1'b1; b8.mode = 1'b1; b8.mask = 8'b1010_0101;
        seq[0] = 3'd0; seq[1] = 3'd2; seq[2] = 3'd5; seq[3] = 3'd7; seq[4] = 3'd0; seq[5] = 3'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            check8($sformatf("scan%0d", i), word[seq[i]], seq[i], 1'b1);
        end

        // Single enabled channel is re-selected
        b8.mask = 8'b0000_1000;
        tick();
        check8("single_a", 16'h4444, 3'd3, 1'b1);
        tick();
        check8("single_b", 16'h4444, 3'd3, 1'b1);

        // Empty mask holds out/out_sel and drops valid
        b8.mask = 8'h00;
        tick();
        check8("mask_zero", 16'h4444, 3'd3, 1'b0);

        // Mask restored: resume after held ptr = 3
        b8.mask = 8'b1010_0101;
        tick();
        check8("resume_a", 16'hFFFF, 3'd5, 1'b1);
        tick();
        check8("resume_b", 16'hEEEE, 3'd7, 1'b1);

        // Direct sel 4, then en low for three cycles
        b8.mode = 1'b0; b8.sel = 3'd4;
        tick();
        check8("dir4", 16'hCCCC, 3'd4, 1'b1);
        b8.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check8($sformatf("en_low%0d", i), 16'hCCCC, 3'd4, 1'b0);
        end

        // Switch to scan with all channels: continues after channel 4
        b8.en = 1'b1; b8.mode = 1'b1; b8.mask = 8'hFF;
        seq[0] = 3'd5; seq[1] = 3'd6; seq[2] = 3'd7; seq[3] = 3'd0; seq[4] = 3'd1; seq[5] = 3'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            check8($sformatf("switch%0d", i), word[seq[i]], seq[i], 1'b1);
        end
        tick(); tick(); tick();
        check8("reach5", 16'hFFFF, 3'd5, 1'b1);

        // Reset in the middle of a scan, then first pick is channel 0
        reset = 1'b1;
        tick();
        check8("mid_reset", 16'h0000, 3'd0, 1'b0);
        reset = 1'b0;
        tick();
        check8("post_reset0", 16'hAAAA, 3'd0, 1'b1);
        tick();
        check8("post_reset1", 16'h0000, 3'd1, 1'b1);

        // Five-way instance: in-range and out-of-range direct selects
        b5.en = 1'b1; b5.mode = 1'b0; b5.sel = 3'd3;
        tick();
        check5("w5_dir3", 16'h4444, 3'd3, 1'b1);
        b5.sel = 3'd6;
        tick();
        check5("w5_sel6", 16'h4444, 3'd3, 1'b0);
        b5.sel = 3'd4;
        tick();
        check5("w5_dir4", 16'hCCCC, 3'd4, 1'b1);
        b5.sel = 3'd5;
        tick();
        check5("w5_sel5", 16'hCCCC, 3'd4, 1'b0);

        // Five-way scan wraps from channel 4 back to channel 0
        b5.mode = 1'b1; b5.mask = 5'b1_0001;
        tick();
        check5("w5_wrap0", 16'hAAAA, 3'd0, 1'b1);
        tick();
        check5("w5_wrap4", 16'hCCCC, 3'd4, 1'b1);
        tick();
        check5("w5_wrap0b", 16'hAAAA, 3'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
